// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage: FSM states, MEM/WB payload layout,
// MEM/WB reset values and the writeback-select encodings.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // mem_to_reg encodings shared with the writeback mux.
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // PC+4 seen by writeback out of reset is the text-segment base.
  localparam logic [31:0] MEMWB_PC_RESET = 32'h0040_0000;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [4:0]  wr_reg;
    logic [31:0] alu_out;
    logic [31:0] mem_data;
    logic [31:0] pc_plus_4;
  } memwb_t;

  localparam memwb_t MEMWB_RESET = '{
    reg_write:  1'b0,
    mem_to_reg: WB_SEL_ALU,
    wr_reg:     5'd0,
    alu_out:    32'd0,
    mem_data:   32'd0,
    pc_plus_4:  MEMWB_PC_RESET
  };

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the write enable; the other
// fields keep their previous values.
module mem_wb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  // Load the completed MEM result, or squash the write while the stage stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= MEMWB_RESET;
    end else if (bubble) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // pre-edge values regardless of block evaluation order.
      q.reg_write <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory requests from EX/MEM, stalls the
// upstream pipeline while an access is outstanding, aborts after TIMEOUT
// cycles in REQ+WAIT, and feeds the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- misaligned accesses are not
// issued; they complete at once with mem_misalign pulsed and the write killed.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic [31:0] reg_b,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [1:0]  mem_to_reg,
  input  logic [4:0]  wr_reg,
  input  logic [31:0] pc_plus_4,
  output logic        dm_req_valid,
  input  logic        dm_req_ready,
  output logic        dm_req_we,
  output logic [31:0] dm_req_addr,
  output logic [31:0] dm_req_wdata,
  input  logic        dm_resp_valid,
  input  logic [31:0] dm_resp_rdata,
  output logic        mem_stall,
  output logic        wb_reg_write,
  output logic [1:0]  wb_mem_to_reg,
  output logic [4:0]  wb_wr_reg,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_pc_plus_4,
  output logic        mem_err,
  output logic        mem_misalign
);

  // Counter value during the last permitted REQ/WAIT cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt;
  logic        tmo_hit;
  logic        err_set;
  logic        access;
  logic        misaligned;
  logic        issue;
  logic        req_we_q;
  logic [31:2] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [31:0] rdata_q;
  memwb_t      memwb_d;
  memwb_t      memwb_q;

  // A request with both control bits set is handled as a store.
  assign access  = mem_read | mem_write;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (alu_out[1:0] != 2'b00);

  // One-cycle pulse in DONE for an access rejected on alignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_misalign <= 1'b0;
    else       mem_misalign <= (state == IDLE) & access & misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  assign issue = (state == IDLE) & access & ~misaligned;

  // Next-state logic for the request/response handshake with timeout abort.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      IDLE: if (access) state_nxt = misaligned ? DONE : REQ;
      REQ: begin
        if (dm_req_ready) begin
          state_nxt = req_we_q ? DONE : WAIT;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          err_set   = 1'b1;
        end
      end
      WAIT: begin
        if (dm_resp_valid) begin
          state_nxt = DONE;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          err_set   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, timeout counter, latched request and captured read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= 8'd0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      mem_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_err <= err_set;
      if (state == IDLE) begin
        // Clearing here means the count starts at zero on entry to REQ and
        // stores/aborts complete with zero read data.
        tmo_cnt <= 8'd0;
        rdata_q <= '0;
      end else if ((state == REQ) || (state == WAIT)) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (issue) begin
        req_we_q    <= mem_write;
        req_addr_q  <= alu_out[31:2];
        req_wdata_q <= reg_b;
      end
      if ((state == WAIT) && dm_resp_valid) rdata_q <= dm_resp_rdata;
    end
  end

  assign dm_req_valid = (state == REQ);
  assign dm_req_we    = req_we_q;
  assign dm_req_addr  = {req_addr_q, 2'b00};
  assign dm_req_wdata = req_wdata_q;

  assign mem_stall = ((state == IDLE) & access) | (state == REQ) | (state == WAIT);

  // MEM/WB payload; mem_err/mem_misalign are high only in DONE of an abort.
  always_comb begin
    memwb_d.reg_write  = reg_write & ~(mem_err | mem_misalign);
    memwb_d.mem_to_reg = mem_to_reg;
    memwb_d.wr_reg     = wr_reg;
    memwb_d.alu_out    = alu_out;
    memwb_d.mem_data   = (state == DONE) ? rdata_q : 32'd0;
    memwb_d.pc_plus_4  = pc_plus_4;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .reset  (reset),
    .bubble (mem_stall),
    .d      (memwb_d),
    .q      (memwb_q)
  );

  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_wr_reg     = memwb_q.wr_reg;
  assign wb_alu_out    = memwb_q.alu_out;
  assign wb_mem_data   = memwb_q.mem_data;
  assign wb_pc_plus_4  = memwb_q.pc_plus_4;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: randomized instruction stream and
// memory latencies against a transaction-level model, plus directed cases.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_out, reg_b, pc_plus_4;
  logic        mem_read, mem_write, reg_write;
  logic [1:0]  mem_to_reg;
  logic [4:0]  wr_reg;
  logic        dm_req_valid, dm_req_ready, dm_req_we;
  logic [31:0] dm_req_addr, dm_req_wdata;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_rdata;
  logic        mem_stall, wb_reg_write, mem_err, mem_misalign;
  logic [1:0]  wb_mem_to_reg;
  logic [4:0]  wb_wr_reg;
  logic [31:0] wb_alu_out, wb_mem_data, wb_pc_plus_4;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .alu_out(alu_out), .reg_b(reg_b),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .wr_reg(wr_reg), .pc_plus_4(pc_plus_4),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata),
    .mem_stall(mem_stall),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_wr_reg(wb_wr_reg),
    .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_pc_plus_4(wb_pc_plus_4),
    .mem_err(mem_err), .mem_misalign(mem_misalign)
  );

  typedef struct {
    logic        mem_read, mem_write, reg_write;
    logic [1:0]  mem_to_reg;
    logic [4:0]  wr_reg;
    logic [31:0] alu_out, reg_b, pc_plus_4;
  } ins_t;

  typedef struct {
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [4:0]  wr_reg;
    logic [31:0] alu_out, mem_data, pc_plus_4;
  } wb_t;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model expectations for the current cycle.
  logic        exp_stall, exp_valid, exp_we, exp_err, exp_mis;
  logic [31:0] exp_addr, exp_wdata;
  wb_t         exp_wb, last_result;
  bit          last_stall;

  // Observations used by the hand-computed directed checks.
  int          obs_stall, obs_wbw, obs_err, obs_mis, obs_vld;
  logic [31:0] obs_mem_data, obs_alu, obs_addr, obs_wdata;
  logic [4:0]  obs_wr_reg;
  logic        obs_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Per-cycle comparison of every meaningful DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_stall", mem_stall, exp_stall);
      check("dm_req_valid", dm_req_valid, exp_valid);
      if (exp_valid) begin
        check("dm_req_we", dm_req_we, exp_we);
        check("dm_req_addr", dm_req_addr, exp_addr);
        check("dm_req_wdata", dm_req_wdata, exp_wdata);
      end
      check("mem_err", mem_err, exp_err);
      check("mem_misalign", mem_misalign, exp_mis);
      check("wb_reg_write", wb_reg_write, exp_wb.reg_write);
      check("wb_mem_to_reg", wb_mem_to_reg, exp_wb.mem_to_reg);
      check("wb_wr_reg", wb_wr_reg, exp_wb.wr_reg);
      check("wb_alu_out", wb_alu_out, exp_wb.alu_out);
      check("wb_mem_data", wb_mem_data, exp_wb.mem_data);
      check("wb_pc_plus_4", wb_pc_plus_4, exp_wb.pc_plus_4);
      if (mem_stall) obs_stall++;
      if (mem_err) obs_err++;
      if (mem_misalign) obs_mis++;
      if (dm_req_valid) begin
        obs_vld++;
        obs_addr = dm_req_addr;
        obs_wdata = dm_req_wdata;
        obs_we = dm_req_we;
      end
      if (wb_reg_write) begin
        obs_wbw++;
        obs_mem_data = wb_mem_data;
        obs_wr_reg = wb_wr_reg;
        obs_alu = wb_alu_out;
      end
    end
  end

  task automatic obs_clear();
    obs_stall = 0; obs_wbw = 0; obs_err = 0; obs_mis = 0; obs_vld = 0;
    obs_mem_data = '0; obs_alu = '0; obs_addr = '0; obs_wdata = '0;
    obs_wr_reg = '0; obs_we = 1'b0;
  endtask

  task automatic drive_ins(input ins_t i);
    mem_read = i.mem_read; mem_write = i.mem_write; reg_write = i.reg_write;
    mem_to_reg = i.mem_to_reg; wr_reg = i.wr_reg; alu_out = i.alu_out;
    reg_b = i.reg_b; pc_plus_4 = i.pc_plus_4;
  endtask

  function automatic ins_t mk(input logic rd, input logic wr, input logic rw,
                              input logic [4:0] dst, input logic [31:0] a,
                              input logic [31:0] b);
    ins_t i;
    i.mem_read = rd; i.mem_write = wr; i.reg_write = rw;
    i.mem_to_reg = rd ? 2'b01 : 2'b00; i.wr_reg = dst;
    i.alu_out = a; i.reg_b = b; i.pc_plus_4 = $urandom;
    return i;
  endfunction

  // One instruction held in EX/MEM until it leaves the stage. rd = cycles of
  // ready low in REQ, wd = extra WAIT cycles before the response.
  task automatic run_instr(input ins_t ins, input int rd, input int wd,
                           input logic [31:0] rdata);
    bit acc, wr, mis, abort;
    int h, r, busy, stall_n;
    acc = ins.mem_read | ins.mem_write;
    wr = ins.mem_write;
    mis = 1'b0;
    abort = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = acc && (ins.alu_out[1:0] != 2'b00);
`endif
    h = 1 + rd;
    r = h + 1 + wd;
    if (!acc) stall_n = 0;
    else if (mis) stall_n = 1;
    else begin
      busy = wr ? rd + 1 : rd + 1 + wd + 1;
      if (busy > TIMEOUT) begin
        busy = TIMEOUT;
        abort = 1'b1;
      end
      stall_n = 1 + busy;
    end
    for (int c = 0; c <= stall_n; c++) begin
      @(posedge clk); #1;
      if (last_stall) exp_wb.reg_write = 1'b0;
      else exp_wb = last_result;
      drive_ins(ins);
      if (acc && !mis && c >= 1 && c < h) dm_req_ready = 1'b0;
      else if (acc && !mis && c == h) dm_req_ready = 1'b1;
      else dm_req_ready = 1'($urandom_range(0, 1));
      if (acc && !mis && !wr && c > h && c < r) begin
        dm_resp_valid = 1'b0;
        dm_resp_rdata = $urandom;
      end else if (acc && !mis && !wr && c == r) begin
        dm_resp_valid = 1'b1;
        dm_resp_rdata = rdata;
      end else begin
        dm_resp_valid = 1'($urandom_range(0, 1));
        dm_resp_rdata = $urandom;
      end
      exp_stall = (c < stall_n);
      exp_valid = acc && !mis && c >= 1 && c <= h && c < stall_n;
      if (exp_valid) begin
        exp_we = wr;
        exp_addr = {ins.alu_out[31:2], 2'b00};
        exp_wdata = ins.reg_b;
      end
      exp_err = abort && (c == stall_n);
      exp_mis = mis && (c == stall_n);
      last_stall = exp_stall;
      if (!exp_stall) begin
        last_result.reg_write  = ins.reg_write & ~(abort | mis);
        last_result.mem_to_reg = ins.mem_to_reg;
        last_result.wr_reg     = ins.wr_reg;
        last_result.alu_out    = ins.alu_out;
        last_result.mem_data   = (acc && !wr && !abort && !mis) ? rdata : 32'd0;
        last_result.pc_plus_4  = ins.pc_plus_4;
      end
      chk_en = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  ins_t nop, cur;
  int   kind;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nop = '{mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, mem_to_reg: 2'b00,
            wr_reg: 5'd0, alu_out: 32'd0, reg_b: 32'd0, pc_plus_4: 32'd0};
    reset = 1'b1;
    drive_ins(nop);
    dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_rdata = '0;
    obs_clear();
    #12;
    check("rst_wb_pc_plus_4", wb_pc_plus_4, 32'h0040_0000);
    check("rst_wb_reg_write", wb_reg_write, 1'b0);
    check("rst_wb_alu_out", wb_alu_out, 32'd0);
    check("rst_dm_req_valid", dm_req_valid, 1'b0);
    check("rst_mem_err", mem_err, 1'b0);
    check("rst_mem_misalign", mem_misalign, 1'b0);
    check("rst_mem_stall", mem_stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    last_stall = 1'b0;
    last_result = '{reg_write: 1'b0, mem_to_reg: 2'b00, wr_reg: 5'd0,
                    alu_out: 32'd0, mem_data: 32'd0, pc_plus_4: 32'd0};

    // sw with ready already high.
    obs_clear();
    cur = mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h1001_0004, 32'hCAFE_F00D);
    run_instr(cur, 0, 0, 32'd0);
    run_instr(nop, 0, 0, 32'd0);
    check("sw_stall_cycles", obs_stall, 2);
    check("sw_req_cycles", obs_vld, 1);
    check("sw_req_addr", obs_addr, 32'h1001_0004);
    check("sw_req_wdata", obs_wdata, 32'hCAFE_F00D);
    check("sw_req_we", obs_we, 1'b1);
    check("sw_wb_writes", obs_wbw, 0);

    // lw, response three cycles after the handshake.
    obs_clear();
    cur = mk(1'b1, 1'b0, 1'b1, 5'd8, 32'h1001_0008, 32'd0);
    run_instr(cur, 0, 2, 32'h1234_5678);
    run_instr(nop, 0, 0, 32'd0);
    check("lw_stall_cycles", obs_stall, 5);
    check("lw_wb_writes", obs_wbw, 1);
    check("lw_wb_mem_data", obs_mem_data, 32'h1234_5678);
    check("lw_wb_wr_reg", obs_wr_reg, 5'd8);

    // add: no memory access.
    obs_clear();
    cur = mk(1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0055, 32'd7);
    run_instr(cur, 0, 0, 32'd0);
    run_instr(nop, 0, 0, 32'd0);
    check("add_stall_cycles", obs_stall, 0);
    check("add_wb_writes", obs_wbw, 1);
    check("add_wb_alu_out", obs_alu, 32'h0000_0055);
    check("add_wb_mem_data", obs_mem_data, 32'd0);

    // lw whose response never comes.
    obs_clear();
    cur = mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h1001_0010, 32'd0);
    run_instr(cur, 0, 100000, 32'hFFFF_FFFF);
    run_instr(nop, 0, 0, 32'd0);
    check("tmo_lw_err_pulses", obs_err, 1);
    check("tmo_lw_wb_writes", obs_wbw, 0);
    check("tmo_lw_stall_cycles", obs_stall, TIMEOUT + 1);

    // sw whose request is never accepted.
    obs_clear();
    cur = mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h1001_0020, 32'h0BAD_F00D);
    run_instr(cur, 100000, 0, 32'd0);
    run_instr(nop, 0, 0, 32'd0);
    check("tmo_sw_err_pulses", obs_err, 1);
    check("tmo_sw_req_cycles", obs_vld, TIMEOUT);

`ifdef MEM_ALIGN_CHECK_EN
    obs_clear();
    cur = mk(1'b1, 1'b0, 1'b1, 5'd4, 32'h1001_0002, 32'd0);
    run_instr(cur, 0, 0, 32'h1111_1111);
    run_instr(nop, 0, 0, 32'd0);
    check("mis_req_cycles", obs_vld, 0);
    check("mis_pulses", obs_mis, 1);
    check("mis_stall_cycles", obs_stall, 1);
    check("mis_wb_writes", obs_wbw, 0);
`endif

    // Randomized instruction stream with random memory latencies.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      cur = mk(kind == 1 || kind == 3, kind == 2 || kind == 3,
               1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom);
      cur.mem_to_reg = 2'($urandom);
      run_instr(cur, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset while the request is pending: valid drops without a clock edge.
    chk_en = 1'b0;
    cur = mk(1'b1, 1'b0, 1'b1, 5'd5, 32'h1001_0040, 32'd0);
    drive_ins(cur);
    dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("rst_req_valid_before", dm_req_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_req_valid_async", dm_req_valid, 1'b0);
    drive_ins(nop);
    @(negedge clk);
    reset = 1'b0;

    // Reset while waiting for read data, followed by a late response.
    drive_ins(cur);
    dm_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dm_req_ready = 1'b0;
    #1;
    reset = 1'b1;
    drive_ins(nop);
    #1;
    check("rstw_wb_reg_write", wb_reg_write, 1'b0);
    check("rstw_wb_pc_plus_4", wb_pc_plus_4, 32'h0040_0000);
    check("rstw_wb_mem_data", wb_mem_data, 32'd0);
    check("rstw_dm_req_valid", dm_req_valid, 1'b0);
    check("rstw_mem_stall", mem_stall, 1'b0);
    check("rstw_mem_err", mem_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    dm_resp_valid = 1'b1;
    dm_resp_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dm_resp_valid = 1'b0;
    @(posedge clk); #1;
    check("late_resp_wb_reg_write", wb_reg_write, 1'b0);
    check("late_resp_wb_mem_data", wb_mem_data, 32'd0);
    check("late_resp_mem_stall", mem_stall, 1'b0);
    check("late_resp_dm_req_valid", dm_req_valid, 1'b0);

    // Resume model-checked traffic after the reset.
    last_stall = 1'b0;
    last_result = '{reg_write: 1'b0, mem_to_reg: 2'b00, wr_reg: 5'd0,
                    alu_out: 32'd0, mem_data: 32'd0, pc_plus_4: 32'd0};
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 3);
      cur = mk(kind == 1 || kind == 3, kind == 2 || kind == 3,
               1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom);
      run_instr(cur, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

MEM-stage controller for the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs, runs a valid/ready request plus a response handshake to a multi-cycle data memory, and stalls the upstream pipeline while an access is outstanding. It also contains the MEM/WB pipeline register, loading it with a bubble while stalled and with the completed result otherwise.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before the access is aborted.

Ports:
- Clock and reset (already decided): reset reset, asynchronous, active-high; clock clk.
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- alu_out  in  32  EX/MEM ALU result; this is the memory address
- reg_b  in  32  EX/MEM store data
- mem_read, mem_write, reg_write  in  1 each  EX/MEM control bits
- mem_to_reg  in  2  EX/MEM writeback select
- wr_reg  in  5  EX/MEM destination register
- pc_plus_4  in  32  EX/MEM PC+4
- dm_req_valid  out  1  memory request valid
- dm_req_ready  in  1  memory accepts the request
- dm_req_we  out  1  1 = write, 0 = read
- dm_req_addr  out  32  request address
- dm_req_wdata  out  32  write data
- dm_resp_valid  in  1  read data valid
- dm_resp_rdata  in  32  read data
- mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- wb_reg_write  out  1  MEM/WB register output
- wb_mem_to_reg  out  2  MEM/WB register output
- wb_wr_reg  out  5  MEM/WB register output
- wb_alu_out, wb_mem_data, wb_pc_plus_4  out  32 each  MEM/WB register outputs
- mem_err  out  1  registered one-cycle pulse on timeout
- mem_misalign  out  1  registered one-cycle pulse; see Configuration

## Operation
- access = mem_read | mem_write. If both are set, the access is treated as a write.
- The FSM has four states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - access = 1: go to REQ and latch address, write data and we.
  - access = 0: pass-through; MEM/WB loads the EX/MEM values and wb_mem_data = 0.
- REQ: dm_req_valid = 1.
  - On dm_req_ready, a write goes to DONE and a read goes to WAIT.
- WAIT: on dm_resp_valid, capture dm_resp_rdata and go to DONE.
- DONE:
  - MEM/WB loads the EX/MEM values, with wb_mem_data = captured read data (0 for writes).
  - Next state is IDLE.
- mem_stall = (IDLE & access) | REQ | WAIT. It is 0 in DONE, so EX/MEM advances at the DONE edge and the same access is never re-issued.
- While mem_stall = 1, MEM/WB loads a bubble: wb_reg_write = 0 and the remaining fields hold their values.
- dm_resp_valid outside WAIT is ignored. Ready held high with no request is ignored.
- dm_req_* hold stable while dm_req_valid = 1. In other states, valid = 0 and addr, wdata and we hold their last values.
- Timeout counter, 8 bits:
  - Clears on entry to REQ and increments in REQ and WAIT.
  - When it reaches TIMEOUT: go to DONE, wb_mem_data = 0, wb_reg_write forced to 0, and mem_err pulses.

## Timing
- Reset values: state IDLE, all wb_* = 0 except wb_pc_plus_4 = 32'h00400000, dm_req_valid = 0, mem_err = 0, mem_misalign = 0.
- Store with ready already high: 2 stall cycles (IDLE, REQ). DONE follows on the third cycle.
- Load with ready high and the response one cycle after the handshake: 3 stall cycles (IDLE, REQ, WAIT).
- Response in the same cycle as entering WAIT is captured. Each additional wait cycle adds one stall cycle.
- Reset mid-access: immediate return to IDLE, and dm_req_valid drops asynchronously. A late response is dropped.
- Back-to-back accesses: DONE → IDLE → REQ, with 1 non-stall cycle between them.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - In IDLE, an access with alu_out[1:0] != 0 issues no request.
  - The FSM goes directly to DONE, wb_reg_write = 0 and mem_misalign pulses.
  - Stall is 1 cycle.
- MEM_ALIGN_CHECK_EN undefined:
  - dm_req_addr[1:0] is forced to 2'b00.
  - mem_misalign is tied to 0.

## Structure
- Shared package holds:
  - the state enum (IDLE/REQ/WAIT/DONE) and the constant MEMWB_PC_RESET = 32'h00400000;
  - the mem_to_reg encodings shared with the writeback mux.
- One sub-module: mem_wb_reg. It holds the MEM/WB flops, with a bubble input and an asynchronous reset.

## Test plan
- sw, alu_out=0x10010004, reg_b=0xCAFEF00D, ready=1: one request with we=1 and matching addr/wdata; mem_stall high for 2 cycles; wb_reg_write=0.
- lw, wr_reg=8, ready=1, response 0x12345678 three cycles after the handshake: mem_stall high for 5 cycles; wb_mem_data=0x12345678, wb_wr_reg=8, wb_reg_write=1 for exactly one cycle.
- add, no access: zero stall; MEM/WB equals the EX/MEM values one cycle later.
- lw with dm_resp_valid never asserted, TIMEOUT=255: mem_err pulses once; wb_reg_write=0; the pipeline resumes.
- reset asserted in WAIT, then a late response: all outputs at reset values; the response is ignored and no MEM/WB write occurs.
- MEM_ALIGN_CHECK_EN, lw at 0x10010002: no dm_req_valid; mem_misalign pulses; 1 stall cycle; wb_reg_write=0.
